cpu_clk_rst_gen: RTL and testbench
==================================

CPU_CLK_RST_GEN -- requirements
Module: cpu_clk_rst_gen

Interface
REQ-001 SHALL have parameter DIV, default 2, meaning system clocks per CPU clock period (even, >= 2).
REQ-002 SHALL have parameter RST_CYCLES, default 5, meaning system clocks cpu_resetn is held low after resetn release (>= 1).
REQ-003 SHALL have parameter CNT_W, default 32, meaning width of the CPU cycle counter.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, with ports named clock and resetn.
REQ-005 SHALL have port: clock  in  1  system (memory-rate) clock; all logic is on its rising edge.
REQ-006 SHALL have port: resetn  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: mode  in  2  run mode: 00 RUN, 01 STEP, 10 HALT, 11 BURST.
REQ-008 SHALL have port: step  in  1  launch request, sampled high for one clock.
REQ-009 SHALL have port: burst_len  in  16  CPU periods per BURST launch, sampled at launch.
REQ-010 SHALL have port: cpu_clk  out  1  registered divided CPU clock, glitch-free.
REQ-011 SHALL have port: cpu_clk_en  out  1  one-clock pulse in the clock cycle before each cpu_clk rising edge.
REQ-012 SHALL have port: cpu_resetn  out  1  registered active-low CPU reset.
REQ-013 SHALL have port: busy  out  1  high while a STEP or BURST launch is in progress.
REQ-014 SHALL have port: cycle_cnt  out  CNT_W  count of cpu_clk rising edges with cpu_resetn high.

Function
REQ-015 SHALL keep phase counter ph in 0..DIV-1; cpu_clk = 0 for ph < DIV/2, 1 otherwise, registered.
REQ-016 SHALL advance ph only while gated on; gating decisions are taken only at ph = 0 with cpu_clk low, so no period is truncated.
REQ-017 SHALL assert cpu_clk_en exactly when ph = DIV/2-1 and gated on.
REQ-018 SHALL implement states HOLD, RUN, IDLE, STEP, BURST.
REQ-019 HOLD: SHALL gate on (cpu_clk free-runs during reset) and count RST_CYCLES clocks after resetn rises, then drive cpu_resetn = 1 and go to RUN if mode = 00, otherwise to IDLE, at the next ph = 0.
REQ-020 RUN: SHALL stay gated on; at ph = 0, if mode is not 00, SHALL go to IDLE with ph frozen at 0.
REQ-021 IDLE: SHALL gate off; mode = 00 SHALL go to RUN; step = 1 with mode 01 SHALL go to STEP; step = 1 with mode 11 and burst_len > 0 SHALL go to BURST; step with mode 10 SHALL be ignored.
REQ-022 STEP: SHALL produce exactly one full cpu_clk period (DIV clocks) and then return to IDLE.
REQ-023 BURST: SHALL load a remaining-period counter with burst_len, decrement it at each ph = DIV-1 -> 0 wrap, and return to IDLE when it reaches 0.
REQ-024 burst_len = 0 in BURST mode SHALL launch nothing and leave the state in IDLE.
REQ-025 busy SHALL be 1 in STEP and BURST, registered, and asserted in the clock after the accepted step.
REQ-026 step while busy, in RUN, or in HOLD SHALL be ignored with no queuing.
REQ-027 Mode changes during STEP or BURST SHALL NOT abort the launch; they take effect from IDLE.
REQ-028 cycle_cnt SHALL increment on each cpu_clk 0 -> 1 transition while cpu_resetn = 1 and SHALL wrap modulo 2^CNT_W.

Reset
REQ-029 resetn low SHALL asynchronously force ph = 0, cpu_clk = 0, cpu_clk_en = 0, cpu_resetn = 0, busy = 0, cycle_cnt = 0, burst counter = 0, and state HOLD.
REQ-030 resetn low mid-STEP, mid-BURST, or mid-RUN SHALL abandon the launch immediately, even if that truncates a cpu_clk high phase.
REQ-031 After release, the HOLD sequence of REQ-019 SHALL repeat in full.

Verification
REQ-032 Reset-release scenario: DIV=2, RST_CYCLES=5, mode=00, release resetn -> cpu_clk toggles every clock from release, cpu_resetn rises 5 clocks later at ph=0, and cycle_cnt increments once per 2 clocks.
REQ-033 Divide scenario: DIV=6 in RUN -> cpu_clk is 3 clocks low and 3 clocks high, and cpu_clk_en pulses only at ph=2.
REQ-034 Step scenario: mode=01, pulse step -> exactly one cpu_clk period, busy high for DIV clocks, cycle_cnt +1; a second step while busy changes nothing.
REQ-035 Burst scenario: mode=11, burst_len=4, pulse step -> exactly 4 periods and cycle_cnt +4; with burst_len=0 -> no edges and busy stays 0.
REQ-036 Halt scenario: switch mode 00 -> 10 while cpu_clk is high -> the current period completes, and cpu_clk then rests low with cpu_clk_en = 0.
REQ-037 Reset-abort scenario: assert resetn low mid-burst -> all outputs reach reset values in the same clock; CNT_W=4 with 17 edges -> cycle_cnt = 1.

Source files
------------

// File: rtl/cpu_clk_rst_gen.sv
// Purpose: divides the system clock into a gated CPU clock and sequences the CPU reset.
// Latency: cpu_clk/cpu_resetn/busy/cycle_cnt registered (1 clock); cpu_clk_en is a same-cycle strobe.
// Backpressure: none; step requests arriving while busy, in RUN or in HOLD are dropped.
module cpu_clk_rst_gen #(
    parameter int DIV        = 2,
    parameter int RST_CYCLES = 5,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       mode,
    input  logic             step,
    input  logic [15:0]      burst_len,
    output logic             cpu_clk,
    output logic             cpu_clk_en,
    output logic             cpu_resetn,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int PW  = $clog2(DIV);
    localparam int RCW = $clog2(RST_CYCLES + 1);

    localparam logic [PW-1:0]  PH_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0]  PH_EN   = PW'(DIV / 2 - 1);
    localparam logic [PW-1:0]  PH_HI   = PW'(DIV / 2);
    localparam logic [RCW-1:0] RC_DONE = RCW'(RST_CYCLES - 1);

    localparam logic [1:0] M_RUN   = 2'b00;
    localparam logic [1:0] M_STEP  = 2'b01;
    localparam logic [1:0] M_BURST = 2'b11;

    typedef enum logic [2:0] {
        S_HOLD,
        S_RUN,
        S_IDLE,
        S_STEP,
        S_BURST
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    ph_q, ph_d;
    logic [RCW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [15:0]      burst_cnt_q, burst_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             cpu_clk_q, cpu_clk_d;
    logic             cpu_resetn_q, cpu_resetn_d;
    logic             busy_q, busy_d;
    logic             advance;
    logic             at_zero;
    logic             at_last;
    logic             rise;

    // Next-state, gating and counter logic; gating only changes with ph at 0 and cpu_clk low.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        cpu_resetn_d = cpu_resetn_q;
        advance      = 1'b0;
        at_zero      = (ph_q == '0);
        at_last      = (ph_q == PH_LAST);

        case (state_q)
            S_HOLD: begin
                advance = 1'b1;
                if (rst_cnt_q < RC_DONE) begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end else if (at_zero) begin
                    cpu_resetn_d = 1'b1;
                    if (mode == M_RUN) begin
                        state_d = S_RUN;
                    end else begin
                        // Leaving to IDLE parks the clock low at ph 0.
                        state_d = S_IDLE;
                        advance = 1'b0;
                    end
                end
            end
            S_RUN: begin
                advance = 1'b1;
                if (at_zero && (mode != M_RUN)) begin
                    advance = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (mode == M_RUN) begin
                    state_d = S_RUN;
                end else if (step && (mode == M_STEP)) begin
                    state_d = S_STEP;
                end else if (step && (mode == M_BURST) && (burst_len != 16'd0)) begin
                    state_d     = S_BURST;
                    burst_cnt_d = burst_len;
                end
            end
            S_STEP: begin
                advance = 1'b1;
                if (at_last) begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                advance = 1'b1;
                if (at_last) begin
                    burst_cnt_d = burst_cnt_q - 16'd1;
                    if (burst_cnt_q == 16'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase

        ph_d      = advance ? (at_last ? '0 : ph_q + 1'b1) : ph_q;
        cpu_clk_d = (ph_d >= PH_HI);
        rise      = advance && (ph_q == PH_EN);
        busy_d    = (state_d == S_STEP) || (state_d == S_BURST);

        cycle_cnt_d = cycle_cnt_q;
        if (rise && cpu_resetn_q) begin
            cycle_cnt_d = cycle_cnt_q + 1'b1;
        end
    end

    // State and output registers; reset abandons any launch immediately.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_HOLD;
            ph_q         <= '0;
            rst_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            cpu_clk_q    <= 1'b0;
            cpu_resetn_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ph_q         <= ph_d;
            rst_cnt_q    <= rst_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            cpu_clk_q    <= cpu_clk_d;
            cpu_resetn_q <= cpu_resetn_d;
            busy_q       <= busy_d;
        end
    end

    // The enable strobe is held off while reset is asserted, since HOLD keeps the gate on.
    assign cpu_clk_en = resetn & rise;
    assign cpu_clk    = cpu_clk_q;
    assign cpu_resetn = cpu_resetn_q;
    assign busy       = busy_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule

// File: tb/tb_cpu_clk_rst_gen.sv
module tb_cpu_clk_rst_gen;

    logic        clock;
    logic        resetn;
    logic [1:0]  mode;
    logic        step;
    logic [15:0] burst_len;

    logic       clk_a, en_a, rstn_a, busy_a;
    logic [3:0] cnt_a;
    logic       clk_b, en_b, rstn_b, busy_b;
    logic [7:0] cnt_b;

    int vectors;
    int miscompares;

    cpu_clk_rst_gen #(.DIV(2), .RST_CYCLES(5), .CNT_W(4)) dut_a (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step), .burst_len(burst_len),
        .cpu_clk(clk_a), .cpu_clk_en(en_a), .cpu_resetn(rstn_a), .busy(busy_a), .cycle_cnt(cnt_a)
    );

    cpu_clk_rst_gen #(.DIV(6), .RST_CYCLES(3), .CNT_W(8)) dut_b (
        .clock(clock), .resetn(resetn), .mode(mode), .step(step), .burst_len(burst_len),
        .cpu_clk(clk_b), .cpu_clk_en(en_b), .cpu_resetn(rstn_b), .busy(busy_b), .cycle_cnt(cnt_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: per instance, a phase, an activity kind and a count of
    // system clocks left in the current launch.
    localparam int K_HOLD = 0, K_RUN = 1, K_IDLE = 2, K_LAUNCH = 3;
    int dv[2] = '{2, 6};
    int rc[2] = '{5, 3};
    int cw[2] = '{4, 8};
    int m_ph[2], m_edges[2], m_kind[2], m_left[2], m_cnt[2];
    int m_rstn[2];

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_ph[m] = 0; m_edges[m] = 0; m_kind[m] = K_HOLD;
            m_left[m] = 0; m_cnt[m] = 0; m_rstn[m] = 0;
        end
    endtask

    function automatic int m_gate(int m);
        case (m_kind[m])
            K_HOLD:  return ((m_edges[m] + 1 >= rc[m]) && m_ph[m] == 0 && mode != 2'b00) ? 0 : 1;
            K_RUN:   return (m_ph[m] == 0 && mode != 2'b00) ? 0 : 1;
            K_LAUNCH: return 1;
            default: return 0;
        endcase
    endfunction

    task automatic model_edge(int m);
        int g;
        if (!resetn) return;
        g = m_gate(m);
        if (g == 1 && m_ph[m] == dv[m] / 2 - 1 && m_rstn[m] == 1)
            m_cnt[m] = (m_cnt[m] + 1) % (1 << cw[m]);
        case (m_kind[m])
            K_HOLD: begin
                m_edges[m]++;
                if (m_edges[m] >= rc[m] && m_ph[m] == 0) begin
                    m_rstn[m] = 1;
                    m_kind[m] = (mode == 2'b00) ? K_RUN : K_IDLE;
                end
            end
            K_RUN: if (m_ph[m] == 0 && mode != 2'b00) m_kind[m] = K_IDLE;
            K_IDLE: begin
                if (mode == 2'b00) m_kind[m] = K_RUN;
                else if (step && mode == 2'b01) begin
                    m_kind[m] = K_LAUNCH; m_left[m] = dv[m];
                end else if (step && mode == 2'b11 && burst_len != 0) begin
                    m_kind[m] = K_LAUNCH; m_left[m] = int'(burst_len) * dv[m];
                end
            end
            default: begin
                m_left[m]--;
                if (m_left[m] == 0) m_kind[m] = K_IDLE;
            end
        endcase
        if (g == 1) m_ph[m] = (m_ph[m] + 1) % dv[m];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [31:0] e_en;
        e_en = (resetn && m_gate(0) == 1 && m_ph[0] == dv[0] / 2 - 1) ? 1 : 0;
        chk("A.cpu_clk",    32'(clk_a),  (m_ph[0] >= dv[0] / 2) ? 1 : 0);
        chk("A.cpu_clk_en", 32'(en_a),   e_en);
        chk("A.cpu_resetn", 32'(rstn_a), 32'(m_rstn[0]));
        chk("A.busy",       32'(busy_a), (m_kind[0] == K_LAUNCH) ? 1 : 0);
        chk("A.cycle_cnt",  32'(cnt_a),  32'(m_cnt[0]));
        e_en = (resetn && m_gate(1) == 1 && m_ph[1] == dv[1] / 2 - 1) ? 1 : 0;
        chk("B.cpu_clk",    32'(clk_b),  (m_ph[1] >= dv[1] / 2) ? 1 : 0);
        chk("B.cpu_clk_en", 32'(en_b),   e_en);
        chk("B.cpu_resetn", 32'(rstn_b), 32'(m_rstn[1]));
        chk("B.busy",       32'(busy_b), (m_kind[1] == K_LAUNCH) ? 1 : 0);
        chk("B.cycle_cnt",  32'(cnt_b),  32'(m_cnt[1]));
    endtask

    // Check outputs against the model, then advance one system clock.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check_all();
            @(posedge clock);
            model_edge(0);
            model_edge(1);
            #1;
        end
    endtask

    task automatic pulse_step(input logic [1:0] md, input logic [15:0] bl);
        mode = md; burst_len = bl; step = 1'b1;
        tick(1);
        step = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        resetn = 1'b0; mode = 2'b00; step = 1'b0; burst_len = 16'd0;
        model_reset();
        tick(3);

        // Release in RUN: A's cpu_resetn rises on the fifth clock.
        resetn = 1'b1;
        tick(4);
        chk("A.rstn_before_5", 32'(rstn_a), 32'd0);
        tick(1);
        chk("A.rstn_after_5", 32'(rstn_a), 32'd1);
        tick(30);

        // Halt while A's cpu_clk is high: current period completes, then rests low.
        while (clk_a !== 1'b1 && vectors < 2000) tick(1);
        mode = 2'b10;
        tick(12);
        chk("A.halt_clk", 32'(clk_a), 32'd0);
        chk("B.halt_clk", 32'(clk_b), 32'd0);
        chk("A.halt_en",  32'(en_a),  32'd0);
        tick(5);

        // Single steps, with a second request while busy; HALT step ignored.
        pulse_step(2'b01, 16'd0);
        pulse_step(2'b01, 16'd0);
        tick(12);
        pulse_step(2'b10, 16'd0);
        tick(8);

        // Bursts of 4 and of 0.
        pulse_step(2'b11, 16'd4);
        tick(30);
        pulse_step(2'b11, 16'd0);
        tick(10);
        chk("B.busy_len0", 32'(busy_b), 32'd0);

        // Reset mid-burst, then a 17-period burst wrapping A's 4-bit counter.
        pulse_step(2'b11, 16'd10);
        tick(7);
        resetn = 1'b0;
        model_reset();
        #1;
        chk("A.abort_clk",  32'(clk_a),  32'd0);
        chk("B.abort_busy", 32'(busy_b), 32'd0);
        tick(2);
        mode = 2'b11;
        resetn = 1'b1;
        tick(10);
        pulse_step(2'b11, 16'd17);
        tick(17 * 6 + 10);
        chk("A.wrap_cnt", 32'(cnt_a), 32'd1);
        chk("B.cnt_17",   32'(cnt_b), 32'd17);

        // Randomized traffic against the model.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 7) == 0) mode = 2'($urandom_range(0, 3));
            step = ($urandom_range(0, 3) == 0);
            burst_len = 16'($urandom_range(0, 5));
            if ($urandom_range(0, 199) == 0) begin
                resetn = 1'b0;
                model_reset();
                tick(2);
                resetn = 1'b1;
            end
            tick(1);
        end
        step = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
